// File: rtl/traffic_pkg.sv
// Shared types and constants for the four-way traffic-light controller.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package traffic_pkg;

  // Phase timer width; every phase duration must fit as DUR-1 in this width.
  localparam int TMR_W = 8;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    EW_G = 4'd1,
    EW_Y = 4'd2,
    EW_L = 4'd3,
    EW_R = 4'd4,
    NS_G = 4'd5,
    NS_Y = 4'd6,
    NS_L = 4'd7,
    NS_R = 4'd8
  } state_t;

  // Vehicle signal, bit order {red, yellow, left, green}.
  localparam logic [3:0] RED  = 4'b1000;
  localparam logic [3:0] YEL  = 4'b0100;
  localparam logic [3:0] LEFT = 4'b1010;
  localparam logic [3:0] GRN  = 4'b0001;

  // Pedestrian signal, bit order {red, walk}.
  localparam logic [1:0] WRED = 2'b10;
  localparam logic [1:0] WALK = 2'b01;
  localparam logic [1:0] DARK = 2'b00;

  // Timer reload value for a phase lasting dur cycles (dur in 1..256).
  function automatic logic [TMR_W-1:0] dur_m1(input int dur);
    return TMR_W'(dur - 1);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Load/decrement phase down-counter with a zero flag.
// Latency: load or decrement takes effect on the next rising edge; zero is combinational from count.
// Backpressure: none; load has priority, otherwise counts down and holds at zero.
//
// Ports:
//   clk, reset_n   clock and asynchronous active-low reset (count clears to 0)
//   load, load_val synchronous reload of the counter
//   count, zero    current value and count==0 flag
module phase_timer
  import traffic_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic [TMR_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      // Holding at zero keeps the counter from wrapping if the FSM ever
      // fails to reload it.
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/traffic_top_fsm.sv
// Four-way intersection controller: IDLE all-red until start, then EW/NS green-yellow-left-clear cycle forever.
// Latency: Moore outputs, one cycle from start sample to EW_G; each phase lasts exactly its parameter in cycles.
// Backpressure: none; i_start only sampled in IDLE. Build macro TRAFFIC_PED_FLASH_EN flashes WALK in last 4 green cycles.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset (forces IDLE, all red)
//   i_start               start request, only honoured in IDLE
//   o_e/w/s/n_ct [3:0]    vehicle signals {red,yellow,left,green}
//   o_e/w/s/n_wt [1:0]    pedestrian signals {red,walk}
module traffic_top_fsm
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 2,
  parameter int LEFT_CYC   = 4,
  parameter int CLR_CYC    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_start,
  output logic [3:0] o_e_ct,
  output logic [3:0] o_w_ct,
  output logic [3:0] o_s_ct,
  output logic [3:0] o_n_ct,
  output logic [1:0] o_e_wt,
  output logic [1:0] o_w_wt,
  output logic [1:0] o_s_wt,
  output logic [1:0] o_n_wt
);

  localparam logic [TMR_W-1:0] G_M1 = dur_m1(GREEN_CYC);
  localparam logic [TMR_W-1:0] Y_M1 = dur_m1(YELLOW_CYC);
  localparam logic [TMR_W-1:0] L_M1 = dur_m1(LEFT_CYC);
  localparam logic [TMR_W-1:0] C_M1 = dur_m1(CLR_CYC);

  state_t           state;
  state_t           state_nxt;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic [TMR_W-1:0] tmr_cnt;
  logic             tmr_zero;
  logic [1:0]       walk_val;

  phase_timer u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .count    (tmr_cnt),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and timer control. The timer is reloaded with the next
  // phase's DUR-1 on the same edge the FSM leaves a phase, so every phase
  // starts with a fresh count and lasts exactly DUR cycles.
  always_comb begin
    state_nxt    = state;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    unique case (state)
      IDLE: begin
        // Timer is parked at 0 while idle.
        tmr_load = 1'b1;
        if (i_start) begin
          state_nxt    = EW_G;
          tmr_load_val = G_M1;
        end
      end
      EW_G: if (tmr_zero) begin state_nxt = EW_Y; tmr_load = 1'b1; tmr_load_val = Y_M1; end
      EW_Y: if (tmr_zero) begin state_nxt = EW_L; tmr_load = 1'b1; tmr_load_val = L_M1; end
      EW_L: if (tmr_zero) begin state_nxt = EW_R; tmr_load = 1'b1; tmr_load_val = C_M1; end
      EW_R: if (tmr_zero) begin state_nxt = NS_G; tmr_load = 1'b1; tmr_load_val = G_M1; end
      NS_G: if (tmr_zero) begin state_nxt = NS_Y; tmr_load = 1'b1; tmr_load_val = Y_M1; end
      NS_Y: if (tmr_zero) begin state_nxt = NS_L; tmr_load = 1'b1; tmr_load_val = L_M1; end
      NS_L: if (tmr_zero) begin state_nxt = NS_R; tmr_load = 1'b1; tmr_load_val = C_M1; end
      NS_R: if (tmr_zero) begin state_nxt = EW_G; tmr_load = 1'b1; tmr_load_val = G_M1; end
      default: begin
        // Unused encodings fall back to a safe all-red idle.
        state_nxt = IDLE;
        tmr_load  = 1'b1;
      end
    endcase
  end

`ifdef TRAFFIC_PED_FLASH_EN
  // Last four green cycles: odd timer values blank the WALK, even show it.
  always_comb begin
    walk_val = WALK;
    if ((tmr_cnt <= TMR_W'(3)) && tmr_cnt[0]) begin
      walk_val = DARK;
    end
  end
`else
  logic unused_tmr_cnt;
  assign unused_tmr_cnt = ^tmr_cnt;
  assign walk_val       = WALK;
`endif

  // Moore output decode. Pedestrians cross the approaches that are stopped,
  // so EW green opens the south/north crosswalks and vice versa.
  always_comb begin
    o_e_ct = RED;
    o_w_ct = RED;
    o_s_ct = RED;
    o_n_ct = RED;
    o_e_wt = WRED;
    o_w_wt = WRED;
    o_s_wt = WRED;
    o_n_wt = WRED;
    unique case (state)
      EW_G: begin
        o_e_ct = GRN;
        o_w_ct = GRN;
        o_s_wt = walk_val;
        o_n_wt = walk_val;
      end
      EW_Y: begin o_e_ct = YEL;  o_w_ct = YEL;  end
      EW_L: begin o_e_ct = LEFT; o_w_ct = LEFT; end
      NS_G: begin
        o_s_ct = GRN;
        o_n_ct = GRN;
        o_e_wt = walk_val;
        o_w_wt = walk_val;
      end
      NS_Y: begin o_s_ct = YEL;  o_n_ct = YEL;  end
      NS_L: begin o_s_ct = LEFT; o_n_ct = LEFT; end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_traffic_top_fsm.sv
// Scoreboard bench: the driver steps a timeline model of the intersection
// and queues the expected outputs; a negedge monitor pops and compares, and
// also checks the safety invariant and the EW green re-entry period.
module tb_traffic_top_fsm;

  localparam int G = 8;
  localparam int Y = 2;
  localparam int L = 4;
  localparam int C = 1;
  localparam int HALF = G + Y + L + C;
  localparam int P = 2 * HALF;

  localparam logic [3:0] C_RED = 4'b1000, C_YEL = 4'b0100, C_LEFT = 4'b1010, C_GRN = 4'b0001;
  localparam logic [1:0] W_RED = 2'b10, W_WALK = 2'b01, W_DARK = 2'b00;

  typedef struct packed {
    logic [3:0] e_ct, w_ct, s_ct, n_ct;
    logic [1:0] e_wt, w_wt, s_wt, n_wt;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic i_start = 1'b0;
  logic [3:0] e_ct, w_ct, s_ct, n_ct;
  logic [1:0] e_wt, w_wt, s_wt, n_wt;

  traffic_top_fsm #(
    .GREEN_CYC (G),
    .YELLOW_CYC(Y),
    .LEFT_CYC  (L),
    .CLR_CYC   (C)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .i_start(i_start),
    .o_e_ct (e_ct),
    .o_w_ct (w_ct),
    .o_s_ct (s_ct),
    .o_n_ct (n_ct),
    .o_e_wt (e_wt),
    .o_w_wt (w_wt),
    .o_s_wt (s_wt),
    .o_n_wt (n_wt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  obs_t exp_q[$];

  // Timeline model: 'running' plus the cycle offset t since entering EW green.
  bit running = 1'b0;
  int t = 0;

  // Reach-check handshake from driver to monitor.
  int nsl_req = 0;
  int nsl_seen = 0;
  bit nsl_ok = 1'b0;

  function automatic obs_t ref_out(input bit run, input int tt);
    obs_t o;
    int axis, p, rem;
    logic [3:0] lt;
    logic [1:0] wk;
    o.e_ct = C_RED; o.w_ct = C_RED; o.s_ct = C_RED; o.n_ct = C_RED;
    o.e_wt = W_RED; o.w_wt = W_RED; o.s_wt = W_RED; o.n_wt = W_RED;
    if (run) begin
      axis = tt / HALF;
      p    = tt % HALF;
      wk   = W_RED;
      if (p < G) begin
        lt  = C_GRN;
        wk  = W_WALK;
        rem = G - 1 - p;
`ifdef TRAFFIC_PED_FLASH_EN
        if (rem <= 3 && (rem % 2) == 1) wk = W_DARK;
`endif
      end else if (p < G + Y) begin
        lt = C_YEL;
      end else if (p < G + Y + L) begin
        lt = C_LEFT;
      end else begin
        lt = C_RED;
      end
      if (axis == 0) begin
        o.e_ct = lt; o.w_ct = lt; o.s_wt = wk; o.n_wt = wk;
      end else begin
        o.s_ct = lt; o.n_ct = lt; o.e_wt = wk; o.w_wt = wk;
      end
    end
    return o;
  endfunction

  // One clock of stimulus: advance the model on the edge using the inputs
  // held across it, then drive the next inputs and queue the expectation.
  task automatic cycle(input bit rst, input bit st);
    @(posedge clk);
    if (!reset_n) begin
      running = 1'b0;
    end else if (!running) begin
      if (i_start) begin
        running = 1'b1;
        t = 0;
      end
    end else begin
      t = (t + 1) % P;
    end
    #1;
    reset_n = rst;
    i_start = st;
    if (!rst) running = 1'b0;
    exp_q.push_back(ref_out(running, t));
  endtask

  // Monitor
  int  cyc = 0;
  int  last_g = -1;
  bit  prev_grn = 1'b0;
  always @(negedge clk) begin
    obs_t act, exp_v;
    act = '{e_ct, w_ct, s_ct, n_ct, e_wt, w_wt, s_wt, n_wt};
    cyc++;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL outputs cyc=%0d got=%h expected=%h", cyc, act, exp_v);
      end
    end
    checks++;
    if ((e_ct != C_RED || w_ct != C_RED) && (s_ct != C_RED || n_ct != C_RED)) begin
      errors++;
      $display("FAIL axis_conflict cyc=%0d got e=%b w=%b s=%b n=%b required one axis all red",
               cyc, e_ct, w_ct, s_ct, n_ct);
    end
    checks++;
    if ((e_wt == W_WALK && e_ct != C_RED) || (w_wt == W_WALK && w_ct != C_RED) ||
        (s_wt == W_WALK && s_ct != C_RED) || (n_wt == W_WALK && n_ct != C_RED)) begin
      errors++;
      $display("FAIL walk_vs_traffic cyc=%0d got wt=%b%b%b%b ct=%b %b %b %b required no WALK on moving approach",
               cyc, e_wt, w_wt, s_wt, n_wt, e_ct, w_ct, s_ct, n_ct);
    end
    if (!reset_n) begin
      last_g = -1;
    end else if (e_ct == C_GRN && !prev_grn) begin
      if (last_g >= 0) begin
        checks++;
        if (cyc - last_g != P) begin
          errors++;
          $display("FAIL period cyc=%0d got=%0d required=%0d", cyc, cyc - last_g, P);
        end
      end
      last_g = cyc;
    end
    prev_grn = (e_ct == C_GRN);
    if (nsl_req != nsl_seen) begin
      nsl_seen = nsl_req;
      checks++;
      if (!nsl_ok) begin
        errors++;
        $display("FAIL reach_ns_left got=timeout required=NS_L within budget");
      end
    end
  end

  initial begin
    int target;
    int d;
    bit hit;
    // Reset for 2 cycles, then idle with start low.
    reset_n = 1'b0;
    i_start = 1'b0;
    repeat (2) cycle(1'b0, 1'b0);
    repeat (20) cycle(1'b1, 1'b0);

    // Single-cycle start pulse after a random delay; afterwards i_start is noise.
    d = $urandom_range(1, 5);
    repeat (d) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (3 * P + 5) cycle(1'b1, 1'($urandom % 2));

    // Held start from reset onwards.
    repeat (2) cycle(1'b0, 1'b1);
    repeat (2 * P + 3) cycle(1'b1, 1'b1);

    // Reset during NS protected left, then require a fresh start.
    target = HALF + G + Y + int'($urandom_range(0, L - 2));
    hit = 1'b0;
    for (int k = 0; k < 4 * P; k++) begin
      if (running && t == target) begin
        hit = 1'b1;
        break;
      end
      cycle(1'b1, 1'($urandom % 2));
    end
    nsl_ok = hit;
    nsl_req++;
    repeat (2) cycle(1'b0, 1'($urandom % 2));
    repeat (10) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (P + 4) cycle(1'b1, 1'b0);

    // Random soak with occasional resets and start pulses.
    for (int k = 0; k < 300; k++) begin
      cycle(1'(($urandom % 60) != 0), 1'(($urandom % 8) == 0));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_top_fsm.md
Name: traffic_top_fsm

Overview:
- Four-way intersection traffic-light controller.
- Drives a 4-bit vehicle signal and a 2-bit pedestrian signal for each of the east, west, south and north approaches.
- Waits in an all-red idle state until started, then cycles forever through EW and NS phases of fixed lengths: green, yellow, protected left, all-red clearance.
- It is the top-level FSM of the traffic-light design.

Parameters:
- GREEN_CYC, 8, cycles of the straight-green phase per direction pair.
- YELLOW_CYC, 2, cycles of the yellow phase.
- LEFT_CYC, 4, cycles of the protected-left phase.
- CLR_CYC, 1, cycles of the all-red clearance phase.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_start  input  1  start request, sampled only in IDLE.
- o_e_ct  output  4  east vehicle signal.
- o_w_ct  output  4  west vehicle signal.
- o_s_ct  output  4  south vehicle signal.
- o_n_ct  output  4  north vehicle signal.
- o_e_wt  output  2  east-crosswalk pedestrian signal.
- o_w_wt  output  2  west-crosswalk pedestrian signal.
- o_s_wt  output  2  south-crosswalk pedestrian signal.
- o_n_wt  output  2  north-crosswalk pedestrian signal.

Behaviour:
- Vehicle encoding: {red,yellow,left,green}.
  - RED=4'b1000, YEL=4'b0100, LEFT=4'b1010 (red plus left arrow), GRN=4'b0001.
- Pedestrian encoding: {red,walk}.
  - WRED=2'b10, WALK=2'b01, DARK=2'b00 (DARK is used only by the optional feature).
- States: IDLE, EW_G, EW_Y, EW_L, EW_R, NS_G, NS_Y, NS_L, NS_R.
- Outputs are a Moore decode of the state register only.
- Reset: state=IDLE and timer=0, asynchronously. All ct=RED and all wt=WRED while reset_n=0 and in IDLE.
- IDLE leaves on the first rising edge with i_start=1; next state is EW_G.
  - After leaving IDLE, i_start is ignored; a held or re-pulsed start has no effect.
- Timer: 8-bit down-counter.
  - Loaded with DUR-1 on entry to each timed state.
  - Decremented every cycle.
  - When it reads 0, the FSM advances and the timer loads the next state's DUR-1.
  - Each timed state therefore lasts exactly DUR cycles.
  - All parameters must be 1..256; the timer never wraps.
- Sequence: EW_G(GREEN_CYC) -> EW_Y(YELLOW_CYC) -> EW_L(LEFT_CYC) -> EW_R(CLR_CYC) -> NS_G -> NS_Y -> NS_L -> NS_R -> EW_G. The cycle repeats forever.
- Period is 2*(G+Y+L+C) cycles, i.e. 30 with the defaults.
- EW_x states: e/w ct = GRN / YEL / LEFT / RED respectively; s/n ct = RED.
- NS_x states: the mirror of EW_x.
- Pedestrians: s_wt and n_wt are WALK only in EW_G; e_wt and w_wt are WALK only in NS_G; WRED otherwise.
- Safety invariant: no GRN, YEL or LEFT is ever shown on both axes in the same cycle. A WALK is never shown on a crosswalk whose own approach is non-RED.
- Reset asserted mid-operation: immediate return to IDLE with all-red outputs. A fresh i_start is required afterwards.
- Illegal state encodings recover to IDLE on the next edge.

Optional Feature:
- Macro: TRAFFIC_PED_FLASH_EN.
- Defined: during a G state, when timer<=3, the wt that would show WALK outputs DARK if timer is odd and WALK if timer is even. For timer 3,2,1,0 this gives 00,01,00,01.
- Undefined: WALK is steady for the whole G state.
- All other behaviour is identical either way.

Decomposition:
- Package traffic_pkg holds:
  - the state enum;
  - light constants RED/YEL/LEFT/GRN/WRED/WALK/DARK;
  - timer width constant 8.
- One sub-module, phase_timer, implements the load/decrement down-counter with a zero flag.
- The FSM, output decode and flash logic stay in traffic_top_fsm.

Test Plan:
- Reset low 2 cycles, then reset_n=1 with i_start=0 for 20 cycles -> all ct=4'b1000, all wt=2'b10 throughout.
- Single-cycle i_start pulse, default parameters:
  - next 8 cycles: e/w ct=0001, s/n ct=1000, s/n wt=01, e/w wt=10;
  - then e/w ct=0100 for 2 cycles, 1010 for 4 cycles, 1000 for 1 cycle;
  - then the NS mirror;
  - EW_G re-entered exactly 30 cycles after first entry.
- i_start held high for the whole run -> waveform identical to the single-pulse case.
- Assert reset_n=0 during NS_L -> outputs go all-red immediately. After release, the FSM stays IDLE until i_start, then restarts at EW_G.
- Every cycle over 3 full periods -> the safety invariant holds (no simultaneous non-RED on both axes, no WALK against traffic).
- With TRAFFIC_PED_FLASH_EN defined, EW_G -> s/n wt = 01,01,01,01,00,01,00,01 over its 8 cycles.
